// File: rtl/spi_master_wbuf_pkg.sv
// Shared definitions for the SPI master write buffer: status bit positions and push outcomes.
package spi_master_wbuf_pkg;

   localparam int WB_STAT_OVF   = 3;
   localparam int WB_STAT_UDF   = 2;
   localparam int WB_STAT_FULL  = 1;
   localparam int WB_STAT_EMPTY = 0;

   localparam int PTR_W = 16;

   typedef enum logic [1:0] {
      PUSH_NONE      = 2'd0,
      PUSH_WRITE     = 2'd1,
      PUSH_OVERWRITE = 2'd2,
      PUSH_DROP      = 2'd3
   } push_e;

endpackage

// File: rtl/spi_master_wbuf_mem.sv
// Simple dual-port word RAM with a synchronous, registered read port.
// The array has no reset so that it maps onto block RAM.
module spi_master_wbuf_mem #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // A same-address write and read in one cycle returns the old word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_master_wbuf.sv
// SPI master write buffer: word FIFO between the register map and the SPI shift engine,
// with pointer-load access and a registered event/status vector.
module spi_master_wbuf
   import spi_master_wbuf_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             sys_wb_wr_en,
   input  logic [DW-1:0]    sys_wb_wdata,
   input  logic             sys_wb_waddr_v,
   input  logic [PTR_W-1:0] sys_wb_waddr_i,
   input  logic             sys_wb_raddr_v,
   input  logic [PTR_W-1:0] sys_wb_raddr_i,
   input  logic             sys_wb_mode,
   input  logic             sys_wb_rd_req,
   output logic             sys_wb_rd_valid,
   output logic [DW-1:0]    sys_wb_rd_data,
   output logic [PTR_W-1:0] sys_wb_waddr_o,
   output logic [PTR_W-1:0] sys_wb_raddr_o,
   output logic [3:0]       sys_wb_status
);

   logic [AW:0]        r_wp;
   logic [AW:0]        r_rp;
   logic               r_rd_valid;
   logic               r_ovf;
   logic               r_udf;
   logic               r_full;
   logic               r_empty;
   logic [PTR_W-1:0]   r_waddr_o;
   logic [PTR_W-1:0]   r_raddr_o;

   logic               w_full;
   logic               w_empty;
   logic               w_pop_ok;
   logic               w_udf;
   logic               w_wr;
   push_e              w_push;
   logic [AW-1:0]      w_wl;
   logic [AW-1:0]      w_rl;
   logic [AW:0]        w_wp_adv;
   logic [AW:0]        w_rp_adv;
   logic [AW:0]        w_wp_nxt;
   logic [AW:0]        w_rp_nxt;
   logic               w_full_nxt;
   logic               w_empty_nxt;
   logic               w_unused;

   assign w_wl     = sys_wb_waddr_i[AW-1:0];
   assign w_rl     = sys_wb_raddr_i[AW-1:0];
   assign w_unused = ^{sys_wb_waddr_i[PTR_W-1:AW], sys_wb_raddr_i[PTR_W-1:AW]};

   always_comb begin
      w_empty  = (r_wp == r_rp);
      w_full   = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
      w_pop_ok = sys_wb_rd_req && !sys_wb_raddr_v && !w_empty;
      w_udf    = sys_wb_rd_req && !sys_wb_raddr_v && w_empty;

      w_push = PUSH_NONE;
      if (sys_wb_wr_en && !sys_wb_waddr_v) begin
         if (!w_full || w_pop_ok) w_push = PUSH_WRITE;
         else if (sys_wb_mode)    w_push = PUSH_OVERWRITE;
         else                     w_push = PUSH_DROP;
      end
      w_wr = (w_push == PUSH_WRITE) || (w_push == PUSH_OVERWRITE);

      w_wp_adv = r_wp + {{AW{1'b0}}, w_wr};
      w_rp_adv = r_rp + {{AW{1'b0}}, (w_pop_ok || (w_push == PUSH_OVERWRITE))};

      // Loaded pointers take the wrap bit that keeps (wp - rp) equal to the
      // modulo-depth distance, so the level never reads as full after a load.
      w_wp_nxt = w_wp_adv;
      w_rp_nxt = w_rp_adv;
      if (sys_wb_waddr_v && sys_wb_raddr_v) begin
         w_wp_nxt = {1'b0, w_wl};
         w_rp_nxt = {(w_wl < w_rl), w_rl};
      end else if (sys_wb_waddr_v) begin
         w_wp_nxt = {w_rp_adv[AW] ^ (w_wl < w_rp_adv[AW-1:0]), w_wl};
      end else if (sys_wb_raddr_v) begin
         w_rp_nxt = {w_wp_adv[AW] ^ (w_wp_adv[AW-1:0] < w_rl), w_rl};
      end

      w_empty_nxt = (w_wp_nxt == w_rp_nxt);
      w_full_nxt  = (w_wp_nxt[AW-1:0] == w_rp_nxt[AW-1:0]) && (w_wp_nxt[AW] != w_rp_nxt[AW]);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_rd_valid <= 1'b0;
         r_ovf      <= 1'b0;
         r_udf      <= 1'b0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_waddr_o  <= '0;
         r_raddr_o  <= '0;
      end else begin
         r_wp       <= w_wp_nxt;
         r_rp       <= w_rp_nxt;
         r_rd_valid <= w_pop_ok;
         r_ovf      <= (w_push == PUSH_DROP);
         r_udf      <= w_udf;
         r_full     <= w_full_nxt;
         r_empty    <= w_empty_nxt;
         r_waddr_o  <= {{(PTR_W-AW){1'b0}}, w_wp_nxt[AW-1:0]};
         r_raddr_o  <= {{(PTR_W-AW){1'b0}}, w_rp_nxt[AW-1:0]};
      end
   end

   spi_master_wbuf_mem #(
      .AW (AW),
      .DW (DW)
   ) u_mem (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_we    (w_wr),
      .i_waddr (r_wp[AW-1:0]),
      .i_wdata (sys_wb_wdata),
      .i_re    (w_pop_ok),
      .i_raddr (r_rp[AW-1:0]),
      .o_rdata (sys_wb_rd_data)
   );

   assign sys_wb_rd_valid               = r_rd_valid;
   assign sys_wb_waddr_o                = r_waddr_o;
   assign sys_wb_raddr_o                = r_raddr_o;
   assign sys_wb_status[WB_STAT_OVF]   = r_ovf;
   assign sys_wb_status[WB_STAT_UDF]   = r_udf;
   assign sys_wb_status[WB_STAT_FULL]  = r_full;
   assign sys_wb_status[WB_STAT_EMPTY] = r_empty;

endmodule

// File: tb/tb_spi_master_wbuf.sv
// Bench for spi_master_wbuf: directed scenarios with literal expectations, then random
// traffic compared every cycle against an occupancy-count model of the buffer.
module tb_spi_master_wbuf;

   localparam int AW = 5;
   localparam int DW = 16;
   localparam int D  = 32;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          sys_wb_wr_en = 1'b0;
   logic [DW-1:0] sys_wb_wdata = '0;
   logic          sys_wb_waddr_v = 1'b0;
   logic [15:0]   sys_wb_waddr_i = '0;
   logic          sys_wb_raddr_v = 1'b0;
   logic [15:0]   sys_wb_raddr_i = '0;
   logic          sys_wb_mode = 1'b0;
   logic          sys_wb_rd_req = 1'b0;
   logic          sys_wb_rd_valid;
   logic [DW-1:0] sys_wb_rd_data;
   logic [15:0]   sys_wb_waddr_o;
   logic [15:0]   sys_wb_raddr_o;
   logic [3:0]    sys_wb_status;

   always #5 sys_clk = ~sys_clk;

   spi_master_wbuf #(.AW(AW), .DW(DW)) dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .sys_wb_wr_en    (sys_wb_wr_en),
      .sys_wb_wdata    (sys_wb_wdata),
      .sys_wb_waddr_v  (sys_wb_waddr_v),
      .sys_wb_waddr_i  (sys_wb_waddr_i),
      .sys_wb_raddr_v  (sys_wb_raddr_v),
      .sys_wb_raddr_i  (sys_wb_raddr_i),
      .sys_wb_mode     (sys_wb_mode),
      .sys_wb_rd_req   (sys_wb_rd_req),
      .sys_wb_rd_valid (sys_wb_rd_valid),
      .sys_wb_rd_data  (sys_wb_rd_data),
      .sys_wb_waddr_o  (sys_wb_waddr_o),
      .sys_wb_raddr_o  (sys_wb_raddr_o),
      .sys_wb_status   (sys_wb_status)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: buffer as an address-indexed array, two addresses and an occupancy count.
   logic [DW-1:0] m_mem [D];
   bit            m_known [D];
   int            m_wa, m_ra, m_cnt;
   logic          exp_valid, exp_ovf, exp_udf;
   logic [DW-1:0] exp_data;
   bit            exp_known;

   always @(posedge sys_clk or negedge sys_rst_n) begin : model
      bit push, pop, pop_ok, wr_ok, drop;
      int nwa, nra;
      if (!sys_rst_n) begin
         m_wa = 0; m_ra = 0; m_cnt = 0;
         exp_valid = 0; exp_ovf = 0; exp_udf = 0;
         exp_data = '0; exp_known = 1;
         for (int i = 0; i < D; i++) m_known[i] = 0;
      end else begin
         push   = sys_wb_wr_en && !sys_wb_waddr_v;
         pop    = sys_wb_rd_req && !sys_wb_raddr_v;
         pop_ok = pop && (m_cnt != 0);
         exp_udf   = pop && (m_cnt == 0);
         exp_valid = pop_ok;
         exp_ovf   = 0;
         wr_ok = 0; drop = 0;
         if (pop_ok) begin
            exp_data  = m_mem[m_ra];
            exp_known = m_known[m_ra];
         end
         if (push) begin
            if (m_cnt < D || pop_ok) wr_ok = 1;
            else if (sys_wb_mode) begin wr_ok = 1; drop = 1; end
            else exp_ovf = 1;
         end
         if (wr_ok) begin
            m_mem[m_wa]   = sys_wb_wdata;
            m_known[m_wa] = 1;
         end
         nwa   = (m_wa + int'(wr_ok)) % D;
         nra   = (m_ra + int'(pop_ok) + int'(drop)) % D;
         m_cnt = m_cnt + int'(wr_ok) - int'(pop_ok) - int'(drop);
         if (sys_wb_waddr_v) nwa = int'(sys_wb_waddr_i) % D;
         if (sys_wb_raddr_v) nra = int'(sys_wb_raddr_i) % D;
         if (sys_wb_waddr_v || sys_wb_raddr_v) m_cnt = (nwa - nra + D) % D;
         m_wa = nwa;
         m_ra = nra;
      end
   end

   always @(negedge sys_clk) begin
      if (chk_en && sys_rst_n) begin
         chk("rd_valid", 32'(sys_wb_rd_valid), 32'(exp_valid));
         if (exp_known) chk("rd_data", 32'(sys_wb_rd_data), 32'(exp_data));
         chk("status", 32'(sys_wb_status),
             32'({exp_ovf, exp_udf, (m_cnt == D), (m_cnt == 0)}));
         chk("waddr_o", 32'(sys_wb_waddr_o), 32'(m_wa));
         chk("raddr_o", 32'(sys_wb_raddr_o), 32'(m_ra));
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #2;
   endtask

   task automatic idle();
      sys_wb_wr_en = 0; sys_wb_rd_req = 0;
      sys_wb_waddr_v = 0; sys_wb_raddr_v = 0;
   endtask

   task automatic do_reset();
      idle();
      sys_rst_n = 0;
      repeat (2) tick();
      sys_rst_n = 1;
      tick();
   endtask

   task automatic push(input logic [DW-1:0] w);
      sys_wb_wr_en = 1; sys_wb_wdata = w;
      tick();
      sys_wb_wr_en = 0;
   endtask

   task automatic pop_chk(input string nm, input logic [DW-1:0] e);
      sys_wb_rd_req = 1;
      tick();
      sys_wb_rd_req = 0;
      chk({nm, "_valid"}, 32'(sys_wb_rd_valid), 32'd1);
      chk(nm, 32'(sys_wb_rd_data), 32'(e));
   endtask

   initial begin
      sys_wb_mode = 0;
      do_reset();
      chk_en = 1;

      // basic order
      chk("t1_rst_status", 32'(sys_wb_status), 32'h1);
      chk("t1_rst_waddr", 32'(sys_wb_waddr_o), 32'h0);
      chk("t1_rst_rdata", 32'(sys_wb_rd_data), 32'h0);
      push(16'h1111); push(16'h2222); push(16'h3333);
      chk("t1_not_empty", 32'(sys_wb_status), 32'h0);
      pop_chk("t1_pop0", 16'h1111);
      pop_chk("t1_pop1", 16'h2222);
      pop_chk("t1_pop2", 16'h3333);
      chk("t1_empty", 32'(sys_wb_status), 32'h1);
      chk("t1_waddr", 32'(sys_wb_waddr_o), 32'd3);
      chk("t1_raddr", 32'(sys_wb_raddr_o), 32'd3);
      tick();
      chk("t1_valid_pulse", 32'(sys_wb_rd_valid), 32'd0);

      // full, drop mode
      do_reset();
      for (int i = 1; i <= D; i++) push(16'(i));
      chk("t2_full", 32'(sys_wb_status), 32'h2);
      push(16'hDEAD);
      chk("t2_ovf", 32'(sys_wb_status), 32'hA);
      chk("t2_waddr", 32'(sys_wb_waddr_o), 32'd0);
      tick();
      chk("t2_ovf_pulse", 32'(sys_wb_status), 32'h2);
      for (int i = 1; i <= D; i++) pop_chk("t2_pop", 16'(i));
      chk("t2_empty", 32'(sys_wb_status), 32'h1);

      // full, overwrite mode
      do_reset();
      sys_wb_mode = 1;
      for (int i = 0; i <= D; i++) push(16'(16'h100 + i));
      chk("t3_no_ovf", 32'(sys_wb_status), 32'h2);
      chk("t3_raddr_mid", 32'(sys_wb_raddr_o), 32'd1);
      for (int i = 1; i <= D; i++) pop_chk("t3_pop", 16'(16'h100 + i));
      chk("t3_raddr_end", 32'(sys_wb_raddr_o), 32'd1);
      sys_wb_mode = 0;

      // underflow
      do_reset();
      sys_wb_rd_req = 1; tick(); sys_wb_rd_req = 0;
      chk("t4_udf", 32'(sys_wb_status), 32'h5);
      chk("t4_udf_valid", 32'(sys_wb_rd_valid), 32'd0);
      chk("t4_udf_raddr", 32'(sys_wb_raddr_o), 32'd0);
      tick();
      chk("t4_udf_pulse", 32'(sys_wb_status), 32'h1);
      sys_wb_rd_req = 1; sys_wb_wr_en = 1; sys_wb_wdata = 16'hBEEF;
      tick(); idle();
      chk("t4_udf_push", 32'(sys_wb_status), 32'h4);
      chk("t4_udf_push_waddr", 32'(sys_wb_waddr_o), 32'd1);
      pop_chk("t4_pop", 16'hBEEF);

      // pointer loads
      do_reset();
      sys_wb_waddr_v = 1; sys_wb_waddr_i = 16'h0010; sys_wb_wr_en = 1; sys_wb_wdata = 16'h5555;
      tick(); idle();
      chk("t5_waddr", 32'(sys_wb_waddr_o), 32'h10);
      chk("t5_not_empty", 32'(sys_wb_status), 32'h0);
      sys_wb_raddr_v = 1; sys_wb_raddr_i = 16'h0010;
      tick(); idle();
      chk("t5_raddr", 32'(sys_wb_raddr_o), 32'h10);
      chk("t5_empty", 32'(sys_wb_status), 32'h1);
      sys_wb_raddr_v = 1; sys_wb_raddr_i = 16'h0014;
      tick(); idle();
      chk("t5_level28", 32'(sys_wb_status), 32'h0);
      for (int i = 0; i < 4; i++) push(16'(i));
      chk("t5_full_after4", 32'(sys_wb_status), 32'h2);

      // push+pop on full, then async reset mid-burst
      do_reset();
      for (int i = 0; i < D; i++) push(16'(16'h600 + i));
      sys_wb_wr_en = 1; sys_wb_wdata = 16'h7777; sys_wb_rd_req = 1;
      tick();
      chk("t6_no_ovf", 32'(sys_wb_status), 32'h2);
      chk("t6_valid", 32'(sys_wb_rd_valid), 32'd1);
      chk("t6_oldest", 32'(sys_wb_rd_data), 32'h600);
      tick(); tick();
      #1 sys_rst_n = 0;
      #1;
      chk("t6_rst_valid", 32'(sys_wb_rd_valid), 32'd0);
      chk("t6_rst_data", 32'(sys_wb_rd_data), 32'd0);
      chk("t6_rst_status", 32'(sys_wb_status), 32'h1);
      chk("t6_rst_waddr", 32'(sys_wb_waddr_o), 32'd0);
      chk("t6_rst_raddr", 32'(sys_wb_raddr_o), 32'd0);
      idle();
      tick(); tick();
      sys_rst_n = 1;
      tick();
      chk("t6_release", 32'(sys_wb_status), 32'h1);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         int pw, pr;
         pw = ((c / 400) % 2 == 1) ? 80 : 45;
         pr = ((c / 400) % 2 == 1) ? 30 : 55;
         sys_wb_wr_en   = ($urandom_range(99) < pw);
         sys_wb_rd_req  = ($urandom_range(99) < pr);
         sys_wb_wdata   = 16'($urandom);
         sys_wb_waddr_v = ($urandom_range(59) == 0);
         sys_wb_raddr_v = ($urandom_range(59) == 0);
         sys_wb_waddr_i = 16'($urandom);
         sys_wb_raddr_i = 16'($urandom);
         if ($urandom_range(99) == 0) sys_wb_mode = ~sys_wb_mode;
         tick();
      end
      idle();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
